// File: rtl/array_port_arbiter_pkg.sv
// Shared definitions for the array port arbiter: FSM state encoding and the
// default geometry of the attached RAM array.
package array_port_arbiter_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 20;
  localparam int LANES_DEF  = 2;

  typedef enum logic {
    ST_INIT = 1'b0,  // sweeping the array with zeros, requests blocked
    ST_RUN  = 1'b1   // serving read/write requests
  } state_t;
endpackage

// File: rtl/array_port_arbiter_if.sv
// Request/response bundle between a client and the array port arbiter.
//   rd_*   : read request  (valid/ready, address)
//   wr_*   : write request (valid/ready, address, lane mask, data)
//   resp_* : read response (valid/ready, data)
// master = client side, slave = arbiter side.
interface array_port_arbiter_if
  import array_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
);
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [LANES-1:0]  wr_mask;
  logic [DATA_W-1:0] wr_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;

  modport master (
    output rd_valid, rd_addr, wr_valid, wr_addr, wr_mask, wr_data, resp_ready,
    input  rd_ready, wr_ready, resp_valid, resp_data
  );

  modport slave (
    input  rd_valid, rd_addr, wr_valid, wr_addr, wr_mask, wr_data, resp_ready,
    output rd_ready, wr_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/array_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
//   req[0] = write requester, req[1] = read requester
//   gnt    : one-hot grant (zero when nothing requests)
//   ptr    : current priority, 0 = write first, 1 = read first
// The pointer only moves when both request in the same cycle, handing
// priority to the requester that just lost.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       ptr
);
  assign gnt[0] = req[0] & (~req[1] | ~ptr);
  assign gnt[1] = req[1] & (~req[0] |  ptr);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  ptr <= 1'b0;
    else if (&req) ptr <= ~ptr;
  end
endmodule

// File: rtl/array_port_arbiter.sv
// Single-port RAM front end: zeroes the array after reset/clear, then
// arbitrates one read or write per cycle and returns read data through a
// one-entry response slot.
//   clock, reset_n : clock, async active-low reset
//   bus            : read/write request and read response handshakes
//   clear          : one-cycle pulse, restart array zeroing
//   init_done      : high while serving requests
//   ram_*          : single-port RAM, 1-cycle read latency
module array_port_arbiter
  import array_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LANES  = LANES_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  array_port_arbiter_if.slave bus,
  input  logic               clear,
  output logic               init_done,
  output logic               ram_en,
  output logic               ram_wmode,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [LANES-1:0]   ram_wmask,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic [DATA_W-1:0]  ram_rdata
);
  state_t            state;
  logic [ADDR_W-1:0] counter;
  logic              resp_valid;
  logic              fresh;  // response still comes straight off ram_rdata
  logic [DATA_W-1:0] hold;
  logic              run, rd_elig, ptr;
  logic [1:0]        req, gnt;

  assign run     = (state == ST_RUN);
  // A read may only issue if its response will have somewhere to land.
  assign rd_elig = run & (~resp_valid | bus.resp_ready);
  assign req     = {bus.rd_valid & rd_elig, bus.wr_valid & run};

  rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt),
    .ptr     (ptr)
  );

  // Ready does not depend on the requester's own valid, only on eligibility
  // and whether the other side would win a conflict.
  assign bus.wr_ready   = run & (~req[1] | ~ptr);
  assign bus.rd_ready   = rd_elig & (~req[0] | ptr);
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = fresh ? ram_rdata : hold;
  assign init_done      = run;

  always_comb begin
    ram_en    = 1'b0;
    ram_wmode = 1'b0;
    ram_addr  = '0;
    ram_wmask = '0;
    ram_wdata = '0;
    if (!run) begin
      ram_en    = 1'b1;
      ram_wmode = 1'b1;
      ram_addr  = counter;
      ram_wmask = '1;
    end else if (gnt[0]) begin
      ram_en    = 1'b1;
      ram_wmode = 1'b1;
      ram_addr  = bus.wr_addr;
      ram_wmask = bus.wr_mask;
      ram_wdata = bus.wr_data;
    end else if (gnt[1]) begin
      ram_en    = 1'b1;
      ram_addr  = bus.rd_addr;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_INIT;
      counter    <= '0;
      resp_valid <= 1'b0;
      fresh      <= 1'b0;
      hold       <= '0;
    end else if (clear) begin
      state      <= ST_INIT;
      counter    <= '0;
      resp_valid <= 1'b0;
      fresh      <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          counter <= counter + ADDR_W'(1);
          if (&counter) state <= ST_RUN;
        end
        ST_RUN: begin
          if (gnt[1]) begin
            resp_valid <= 1'b1;
            fresh      <= 1'b1;
          end else if (resp_valid && bus.resp_ready) begin
            resp_valid <= 1'b0;
            fresh      <= 1'b0;
          end else if (resp_valid && fresh) begin
            // Stalled: freeze the data so later writes to the same
            // address (which the RAM read port follows) cannot leak in.
            hold  <= ram_rdata;
            fresh <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_array_port_arbiter.sv
module tb_array_port_arbiter;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 20;
  localparam int LANES  = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LW     = DATA_W / LANES;

  logic              clock;
  logic              reset_n;
  logic              clear;
  logic              init_done;
  logic              ram_en, ram_wmode;
  logic [ADDR_W-1:0] ram_addr;
  logic [LANES-1:0]  ram_wmask;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  int checks = 0;
  int failures = 0;

  array_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES)) bus ();

  array_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .clear     (clear),
    .init_done (init_done),
    .ram_en    (ram_en),
    .ram_wmode (ram_wmode),
    .ram_addr  (ram_addr),
    .ram_wmask (ram_wmask),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // RAM model: rdata follows the registered read address.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] raddr = '0;
  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_wmode) begin
        for (int l = 0; l < LANES; l++)
          if (ram_wmask[l]) mem[ram_addr][l*LW +: LW] <= ram_wdata[l*LW +: LW];
      end else begin
        raddr <= ram_addr;
      end
    end
  end
  assign ram_rdata = mem[raddr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of request inputs at the falling edge; return 1 ns later
  // so combinational outputs can be sampled well before the rising edge.
  task automatic cyc(input logic rv, input logic [ADDR_W-1:0] ra,
                     input logic wv, input logic [ADDR_W-1:0] wa,
                     input logic [LANES-1:0] wm, input logic [DATA_W-1:0] wd,
                     input logic rr);
    @(negedge clock);
    bus.rd_valid = rv; bus.rd_addr = ra;
    bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_mask = wm; bus.wr_data = wd;
    bus.resp_ready = rr;
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; clear = 1'b0;
    bus.rd_valid = 1'b1; bus.rd_addr = '0;
    bus.wr_valid = 1'b1; bus.wr_addr = '0; bus.wr_mask = '0; bus.wr_data = '0;
    bus.resp_ready = 1'b1;
    #3;
    checks++;
    if (init_done !== 1'b0 || bus.rd_ready !== 1'b0 || bus.wr_ready !== 1'b0 || bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: done=%b rd_rdy=%b wr_rdy=%b resp_v=%b, required all 0",
               init_done, bus.rd_ready, bus.wr_ready, bus.resp_valid);
    end
    repeat (2) @(negedge clock);
    // Requests held valid throughout zeroing must never see ready.
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 0) @(negedge clock);
      reset_n = 1'b1;
      #1;
      checks++;
      if (ram_en !== 1'b1 || ram_wmode !== 1'b1 || ram_addr !== ADDR_W'(i) || ram_wdata !== '0 ||
          ram_wmask !== 2'b11 || init_done !== 1'b0 || bus.rd_ready !== 1'b0 || bus.wr_ready !== 1'b0) begin
        failures++;
        $display("FAIL zero_sweep cyc=%0d: en=%b wmode=%b addr=%0d wdata=%h mask=%b done=%b rdy=%b%b, required 1 1 %0d 0 11 0 00",
                 i, ram_en, ram_wmode, ram_addr, ram_wdata, ram_wmask, init_done, bus.rd_ready, bus.wr_ready, i);
      end
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (init_done !== 1'b1) begin
      failures++;
      $display("FAIL init_done_cycle33: got %b, required 1", init_done);
    end
  endtask

  task automatic test_init_reads;
    cyc(1, 0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.rd_ready !== 1'b1 || ram_wmode !== 1'b0) begin
      failures++;
      $display("FAIL init_read_issue: rd_ready=%b wmode=%b, required 1 0", bus.rd_ready, ram_wmode);
    end
    cyc(1, 31, 0, 0, 0, 0, 1);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 20'h0) begin
      failures++;
      $display("FAIL init_read_addr0: valid=%b data=%h, required 1 00000", bus.resp_valid, bus.resp_data);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 20'h0) begin
      failures++;
      $display("FAIL init_read_addr31: valid=%b data=%h, required 1 00000", bus.resp_valid, bus.resp_data);
    end
  endtask

  task automatic test_masked_write;
    cyc(0, 0, 1, 3, 2'b01, 20'h12345, 1);
    checks++;
    if (bus.wr_ready !== 1'b1 || ram_en !== 1'b1 || ram_wmode !== 1'b1 || ram_wmask !== 2'b01 || ram_addr !== 5'd3) begin
      failures++;
      $display("FAIL write_issue: rdy=%b en=%b wmode=%b mask=%b addr=%0d, required 1 1 1 01 3",
               bus.wr_ready, ram_en, ram_wmode, ram_wmask, ram_addr);
    end
    cyc(1, 3, 0, 0, 0, 0, 1);
    checks++;
    if (bus.rd_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL raw_read_issue: rd_ready=%b resp_valid=%b, required 1 0", bus.rd_ready, bus.resp_valid);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 20'h00345) begin
      failures++;
      $display("FAIL raw_lane0: valid=%b data=%h, required 1 00345", bus.resp_valid, bus.resp_data);
    end
    // Zero mask still takes the port.
    cyc(0, 0, 1, 3, 2'b00, 20'hFFFFF, 1);
    checks++;
    if (bus.wr_ready !== 1'b1 || ram_en !== 1'b1 || ram_wmask !== 2'b00) begin
      failures++;
      $display("FAIL mask0_write: rdy=%b en=%b mask=%b, required 1 1 00", bus.wr_ready, ram_en, ram_wmask);
    end
    cyc(0, 0, 1, 3, 2'b10, 20'hABCDE, 1);
    cyc(1, 3, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 20'hABF45) begin
      failures++;
      $display("FAIL lane1_merge: valid=%b data=%h, required 1 abf45", bus.resp_valid, bus.resp_data);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8, 1, 7, 2'b11, 20'h11111, 1);
      checks++;
      if ({bus.wr_ready, bus.rd_ready} !== exp_g[i]) begin
        failures++;
        $display("FAIL rr_grant cyc=%0d: wr/rd=%b, required %b", i, {bus.wr_ready, bus.rd_ready}, exp_g[i]);
      end
    end
    // Read alone: no conflict, pointer stays on write-first.
    cyc(1, 8, 0, 0, 0, 0, 1);
    checks++;
    if (bus.rd_ready !== 1'b1 || bus.resp_valid !== 1'b1 || bus.resp_data !== 20'h0) begin
      failures++;
      $display("FAIL rr_solo_read: rdy=%b valid=%b data=%h, required 1 1 00000",
               bus.rd_ready, bus.resp_valid, bus.resp_data);
    end
    cyc(1, 8, 1, 7, 2'b11, 20'h11111, 1);
    checks++;
    if ({bus.wr_ready, bus.rd_ready} !== 2'b10) begin
      failures++;
      $display("FAIL rr_ptr_held: wr/rd=%b, required 10", {bus.wr_ready, bus.rd_ready});
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] vals [3];
    vals[0] = 20'hA000A; vals[1] = 20'hB000B; vals[2] = 20'hC000C;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, ADDR_W'(10 + i), 2'b11, vals[i], 1);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) cyc(1, ADDR_W'(10 + i), 0, 0, 0, 0, 1);
      else       cyc(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (i < 3 && bus.rd_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready cyc=%0d: got %b, required 1", i, bus.rd_ready);
      end
      if (i > 0 && (bus.resp_valid !== 1'b1 || bus.resp_data !== vals[i-1])) begin
        failures++;
        $display("FAIL b2b_data cyc=%0d: valid=%b data=%h, required 1 %h", i, bus.resp_valid, bus.resp_data, vals[i-1]);
      end
    end
  endtask

  task automatic test_hold;
    cyc(0, 0, 1, 5, 2'b11, 20'h0ABCD, 1);
    cyc(1, 5, 0, 0, 0, 0, 0);
    checks++;
    if (bus.rd_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_issue: rd_ready=%b, required 1", bus.rd_ready);
    end
    cyc(1, 6, 1, 5, 2'b11, 20'hFFFFF, 0);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 20'h0ABCD || bus.rd_ready !== 1'b0 || bus.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_stall1: valid=%b data=%h rd_rdy=%b wr_rdy=%b, required 1 0abcd 0 1",
               bus.resp_valid, bus.resp_data, bus.rd_ready, bus.wr_ready);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1, 5, 0, 0, 0, 0, 0);
      checks++;
      if (bus.resp_data !== 20'h0ABCD || bus.rd_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stall%0d: data=%h rd_rdy=%b, required 0abcd 0", i + 2, bus.resp_data, bus.rd_ready);
      end
    end
    cyc(1, 5, 0, 0, 0, 0, 1);
    checks++;
    if (bus.resp_data !== 20'h0ABCD || bus.rd_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_drain: data=%h rd_rdy=%b, required 0abcd 1", bus.resp_data, bus.rd_ready);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 20'hFFFFF) begin
      failures++;
      $display("FAIL hold_newdata: valid=%b data=%h, required 1 fffff", bus.resp_valid, bus.resp_data);
    end
  endtask

  task automatic test_clear;
    cyc(1, 5, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL clear_pending: resp_valid=%b, required 1", bus.resp_valid);
    end
    clear = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    clear = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b0 || init_done !== 1'b0 || ram_addr !== 5'd0 || ram_wmode !== 1'b1) begin
      failures++;
      $display("FAIL clear_drop: valid=%b done=%b addr=%0d wmode=%b, required 0 0 0 1",
               bus.resp_valid, init_done, ram_addr, ram_wmode);
    end
    for (int i = 1; i < DEPTH; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (ram_addr !== ADDR_W'(i) || ram_wdata !== '0 || init_done !== 1'b0) begin
        failures++;
        $display("FAIL clear_sweep cyc=%0d: addr=%0d wdata=%h done=%b, required %0d 0 0",
                 i, ram_addr, ram_wdata, init_done, i);
      end
    end
    cyc(1, 5, 0, 0, 0, 0, 1);
    cyc(1, 3, 0, 0, 0, 0, 1);
    checks++;
    if (init_done !== 1'b1 || bus.resp_valid !== 1'b1 || bus.resp_data !== 20'h0) begin
      failures++;
      $display("FAIL clear_read5: done=%b valid=%b data=%h, required 1 1 00000", init_done, bus.resp_valid, bus.resp_data);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== 20'h0) begin
      failures++;
      $display("FAIL clear_read3: valid=%b data=%h, required 1 00000", bus.resp_valid, bus.resp_data);
    end
  endtask

  task automatic test_reset_mid;
    cyc(0, 0, 1, 17, 2'b11, 20'h55555, 1);
    cyc(1, 17, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_inflight: valid=%b done=%b, required 0 0", bus.resp_valid, init_done);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 1; i <= 17; i++) cyc(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (ram_addr !== 5'd17 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_reach17: addr=%0d done=%b, required 17 0", ram_addr, init_done);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (ram_addr !== 5'd0 || init_done !== 1'b0 || bus.rd_ready !== 1'b0 || bus.wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: addr=%0d done=%b rdy=%b%b, required 0 0 00",
               ram_addr, init_done, bus.rd_ready, bus.wr_ready);
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 0) cyc(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (ram_en !== 1'b1 || ram_addr !== ADDR_W'(i) || init_done !== 1'b0) begin
        failures++;
        $display("FAIL reset_sweep cyc=%0d: en=%b addr=%0d done=%b, required 1 %0d 0", i, ram_en, ram_addr, init_done, i);
      end
    end
    cyc(1, 17, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (init_done !== 1'b1 || bus.resp_valid !== 1'b1 || bus.resp_data !== 20'h0) begin
      failures++;
      $display("FAIL reset_read17: done=%b valid=%b data=%h, required 1 1 00000", init_done, bus.resp_valid, bus.resp_data);
    end
  endtask

  initial begin
    test_reset;
    test_init_reads;
    test_masked_write;
    test_round_robin;
    test_back_to_back;
    test_hold;
    test_clear;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
